// File: rtl/centering_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : centering_sequencer
// Brief    : Per-channel clear/sum/divide/wait/subtract sequencer that drives
//            the mean-removal datapath of the whitening stage.
// Revision : 1.0 - initial release
// ============================================================================
module centering_sequencer #(
    parameter int N_SAMPLES = 128,
    parameter int N_CH      = 4,
    parameter int DIV_LAT   = 1,
    parameter int CNT_W     = $clog2(N_SAMPLES),
    parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             CLK_cen,
    input  logic             RST_cen,
    input  logic             GO_cen,
    input  logic             HOLD_cen,
    output logic             CEN_Busy,
    output logic             CEN_Done,
    output logic             Clr_ACC,
    output logic             En_SUM,
    output logic             En_DIV,
    output logic             En_SUB,
    output logic [CH_W-1:0]  CH_sel,
    output logic [CNT_W-1:0] ADDR
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_SUM  = 3'd2;
    localparam logic [2:0] S_DIV  = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_SUB  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam int              WAIT_W    = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((DIV_LAT > 0) ? DIV_LAT - 1 : 0);
    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(N_SAMPLES - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              busy_next;
    logic              clr_next;
    logic              div_next;
    logic              done_next;
    logic              sample_step;
    logic              last_addr;
    logic              last_ch;

    // A sample step is one non-held cycle in either streaming state.
    assign sample_step = ((state == S_SUM) || (state == S_SUB)) && !HOLD_cen;
    assign last_addr   = (ADDR == ADDR_LAST);
    assign last_ch     = (CH_sel == CH_LAST);

    always_ff @(posedge CLK_cen or posedge RST_cen) begin
        if (RST_cen) begin
            state    <= S_IDLE;
            CEN_Busy <= 1'b0;
            Clr_ACC  <= 1'b0;
            En_DIV   <= 1'b0;
            CEN_Done <= 1'b0;
        end else begin
            state    <= state_next;
            CEN_Busy <= busy_next;
            Clr_ACC  <= clr_next;
            En_DIV   <= div_next;
            CEN_Done <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (GO_cen) state_next = S_CLR;
            S_CLR:  state_next = S_SUM;
            S_SUM:  if (sample_step && last_addr) state_next = S_DIV;
            S_DIV:  state_next = (DIV_LAT == 0) ? S_SUB : S_WAIT;
            S_WAIT: if (wait_cnt == WAIT_LAST) state_next = S_SUB;
            S_SUB:  if (sample_step && last_addr) state_next = last_ch ? S_DONE : S_CLR;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Registered outputs are decoded from the upcoming state so they line up
    // with the state they describe.
    always_comb begin
        busy_next = (state_next == S_CLR) || (state_next == S_SUM) ||
                    (state_next == S_DIV) || (state_next == S_WAIT) ||
                    (state_next == S_SUB);
        clr_next  = (state_next == S_CLR);
        div_next  = (state_next == S_DIV);
        done_next = (state_next == S_DONE);
        En_SUM    = (state == S_SUM) && !HOLD_cen;
        En_SUB    = (state == S_SUB) && !HOLD_cen;
    end

    always_ff @(posedge CLK_cen or posedge RST_cen) begin
        if (RST_cen) begin
            ADDR     <= '0;
            CH_sel   <= '0;
            wait_cnt <= '0;
        end else begin
            if (sample_step) begin
                ADDR <= last_addr ? '0 : ADDR + CNT_W'(1);
            end
            if ((state == S_SUB) && sample_step && last_addr) begin
                CH_sel <= last_ch ? '0 : CH_sel + CH_W'(1);
            end
            if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_centering_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_centering_sequencer
// Brief    : Directed vector bench for centering_sequencer (4/2/2 and 2/1/0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_centering_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       go, hold, busy, done, clr, sum, div, sub, ch;
    logic [1:0] addr;
    logic       go_s, hold_s, busy_s, done_s, clr_s, sum_s, div_s, sub_s, ch_s;
    logic       addr_s;

    always #5 clk = ~clk;

    centering_sequencer #(.N_SAMPLES(4), .N_CH(2), .DIV_LAT(2)) dut (
        .CLK_cen(clk), .RST_cen(rst), .GO_cen(go), .HOLD_cen(hold),
        .CEN_Busy(busy), .CEN_Done(done), .Clr_ACC(clr), .En_SUM(sum),
        .En_DIV(div), .En_SUB(sub), .CH_sel(ch), .ADDR(addr)
    );

    centering_sequencer #(.N_SAMPLES(2), .N_CH(1), .DIV_LAT(0)) dut_s (
        .CLK_cen(clk), .RST_cen(rst), .GO_cen(go_s), .HOLD_cen(hold_s),
        .CEN_Busy(busy_s), .CEN_Done(done_s), .Clr_ACC(clr_s), .En_SUM(sum_s),
        .En_DIV(div_s), .En_SUB(sub_s), .CH_sel(ch_s), .ADDR(addr_s)
    );

    typedef struct packed {
        logic       busy, done, clr, sum, div, sub, ch;
        logic [1:0] addr;
    } outs_t;

    typedef struct {
        logic  go;
        logic  hold;
        outs_t exp;
    } vec_t;

    vec_t  vt[27];
    vec_t  vs[9];
    outs_t cap[64];
    int    passed = 0;
    int    total  = 0;

    function automatic outs_t mk(input logic b, d, c, s, dv, sb, chv, input logic [1:0] a);
        return '{busy:b, done:d, clr:c, sum:s, div:dv, sub:sb, ch:chv, addr:a};
    endfunction

    function automatic vec_t v(input logic g, h, input outs_t e);
        vec_t r;
        r.go = g; r.hold = h; r.exp = e;
        return r;
    endfunction

    function automatic outs_t now_main();
        return mk(busy, done, clr, sum, div, sub, ch, addr);
    endfunction

    function automatic outs_t now_small();
        return mk(busy_s, done_s, clr_s, sum_s, div_s, sub_s, ch_s, {1'b0, addr_s});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic run(input logic [63:0] gm, input logic [63:0] hm, input int n);
        for (int c = 0; c < n; c++) begin
            go = gm[c]; hold = hm[c];
            #1;
            cap[c] = now_main();
            @(negedge clk);
        end
        go = 1'b0; hold = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n_busy, n_sum0, n_sum1, n_div, n_done;
        outs_t idle0;
        idle0 = mk(0, 0, 0, 0, 0, 0, 0, 0);

        // {go, hold, busy done clr sum div sub ch addr} per cycle
        vt[0]  = v(1, 0, mk(0,0,0,0,0,0,0,0));
        vt[1]  = v(0, 0, mk(1,0,1,0,0,0,0,0));
        vt[2]  = v(0, 0, mk(1,0,0,1,0,0,0,0));
        vt[3]  = v(0, 0, mk(1,0,0,1,0,0,0,1));
        vt[4]  = v(0, 0, mk(1,0,0,1,0,0,0,2));
        vt[5]  = v(0, 0, mk(1,0,0,1,0,0,0,3));
        vt[6]  = v(0, 0, mk(1,0,0,0,1,0,0,0));
        vt[7]  = v(0, 0, mk(1,0,0,0,0,0,0,0));
        vt[8]  = v(0, 0, mk(1,0,0,0,0,0,0,0));
        vt[9]  = v(0, 0, mk(1,0,0,0,0,1,0,0));
        vt[10] = v(0, 0, mk(1,0,0,0,0,1,0,1));
        vt[11] = v(0, 0, mk(1,0,0,0,0,1,0,2));
        vt[12] = v(0, 0, mk(1,0,0,0,0,1,0,3));
        vt[13] = v(0, 0, mk(1,0,1,0,0,0,1,0));
        vt[14] = v(0, 0, mk(1,0,0,1,0,0,1,0));
        vt[15] = v(0, 0, mk(1,0,0,1,0,0,1,1));
        vt[16] = v(0, 0, mk(1,0,0,1,0,0,1,2));
        vt[17] = v(0, 0, mk(1,0,0,1,0,0,1,3));
        vt[18] = v(0, 0, mk(1,0,0,0,1,0,1,0));
        vt[19] = v(0, 0, mk(1,0,0,0,0,0,1,0));
        vt[20] = v(0, 0, mk(1,0,0,0,0,0,1,0));
        vt[21] = v(0, 0, mk(1,0,0,0,0,1,1,0));
        vt[22] = v(0, 0, mk(1,0,0,0,0,1,1,1));
        vt[23] = v(0, 0, mk(1,0,0,0,0,1,1,2));
        vt[24] = v(0, 0, mk(1,0,0,0,0,1,1,3));
        vt[25] = v(0, 0, mk(0,1,0,0,0,0,0,0));
        vt[26] = v(0, 0, mk(0,0,0,0,0,0,0,0));

        vs[0] = v(1, 0, mk(0,0,0,0,0,0,0,0));
        vs[1] = v(0, 0, mk(1,0,1,0,0,0,0,0));
        vs[2] = v(0, 0, mk(1,0,0,1,0,0,0,0));
        vs[3] = v(0, 0, mk(1,0,0,1,0,0,0,1));
        vs[4] = v(0, 0, mk(1,0,0,0,1,0,0,0));
        vs[5] = v(0, 0, mk(1,0,0,0,0,1,0,0));
        vs[6] = v(0, 0, mk(1,0,0,0,0,1,0,1));
        vs[7] = v(0, 0, mk(0,1,0,0,0,0,0,0));
        vs[8] = v(0, 0, mk(0,0,0,0,0,0,0,0));

        rst = 1'b1; go = 1'b0; hold = 1'b0; go_s = 1'b0; hold_s = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset state main", now_main(), idle0);
        check("reset state small", now_small(), idle0);
        rst = 1'b0;
        @(negedge clk);

        // Plain run, cycle-by-cycle against the table
        for (int i = 0; i < 27; i++) begin
            go = vt[i].go; hold = vt[i].hold;
            #1;
            check($sformatf("run cycle %0d", i), now_main(), vt[i].exp);
            @(negedge clk);
        end
        go = 1'b0;

        // Hold for three cycles while ADDR=1 in SUM of channel 0
        run(64'd1, 64'b111 << 3, 32);
        for (int c = 3; c < 6; c++)
            check($sformatf("hold frozen c%0d", c), {cap[c].sum, cap[c].addr}, 3'b001);
        check("hold release", {cap[6].sum, cap[6].addr}, 3'b101);
        n_busy = 0; n_sum0 = 0; n_sum1 = 0; n_done = 0;
        for (int c = 0; c < 32; c++) begin
            n_busy += int'(cap[c].busy);
            n_done += int'(cap[c].done);
            if (cap[c].sum && !cap[c].ch) n_sum0++;
            if (cap[c].sum &&  cap[c].ch) n_sum1++;
        end
        check("hold busy span", n_busy, 27);
        check("hold en_sum ch0", n_sum0, 4);
        check("hold en_sum ch1", n_sum1, 4);
        check("hold done count", n_done, 1);
        check("hold done cycle", int'(cap[28].done), 1);

        // Hold through DIV and WAIT has no effect
        run(64'd1, 64'b111 << 6, 30);
        n_div = 0;
        for (int c = 0; c < 30; c++) n_div += int'(cap[c].div);
        check("div pulses", n_div, 2);
        check("div cycle", cap[6], mk(1,0,0,0,1,0,0,0));
        check("wait cycle 7", cap[7], mk(1,0,0,0,0,0,0,0));
        check("wait cycle 8", cap[8], mk(1,0,0,0,0,0,0,0));
        check("sub after wait", cap[9], mk(1,0,0,0,0,1,0,0));
        check("div-hold done", int'(cap[25].done), 1);

        // GO during SUM and DONE ignored; GO right after DONE restarts
        run((64'd1) | (64'd1 << 3) | (64'd1 << 25) | (64'd1 << 26), 64'd0, 30);
        n_done = 0;
        for (int c = 0; c < 30; c++) n_done += int'(cap[c].done);
        check("go ignored sum", cap[4], mk(1,0,0,1,0,0,0,2));
        check("single done", n_done, 1);
        check("idle after done", cap[26], idle0);
        check("restart clr", cap[27], mk(1,0,1,0,0,0,0,0));
        check("restart sum", cap[28], mk(1,0,0,1,0,0,0,0));
        do_reset();

        // Asynchronous reset mid-SUB, channel 1, ADDR=2
        run(64'd1, 64'd0, 23);
        #1;
        check("pre-reset point", now_main(), mk(1,0,0,0,0,1,1,2));
        rst = 1'b1;
        #1;
        check("async reset clears", now_main(), idle0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle after reset", now_main(), idle0);
        @(negedge clk);
        run(64'd1, 64'd0, 4);
        check("restart ch0 clr", cap[1], mk(1,0,1,0,0,0,0,0));
        check("restart ch0 sum", cap[2], mk(1,0,0,1,0,0,0,0));
        do_reset();

        // Single channel, zero divider latency, two samples
        n_busy = 0;
        for (int i = 0; i < 9; i++) begin
            go_s = vs[i].go; hold_s = vs[i].hold;
            #1;
            check($sformatf("small cycle %0d", i), now_small(), vs[i].exp);
            n_busy += int'(busy_s);
            @(negedge clk);
        end
        go_s = 1'b0;
        check("small busy span", n_busy, 6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
